// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU-facing MMIO window onto a byte-wide UART controller with TX/RX FIFOs.
// Optional feature macro UART_BRIDGE_IRQ_EN adds the CTRL irq_en bit and a registered irq output.
`timescale 1ns/1ps
module uart_mmio_bridge #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        uart_tx_en,
    output logic [31:0] uart_data_send,
    input  logic        uart_tx_res,
    output logic        uart_rx_en,
    input  logic [31:0] uart_data_recv,
    input  logic        uart_rx_res
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [1:0]      A_DATA   = 2'd0;
    localparam logic [1:0]      A_STAT   = 2'd1;
    localparam logic [1:0]      A_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2
    } tx_state_e;

    // Occupancy shown in an 8-bit field; saturates for the 256-deep build.
    function automatic logic [7:0] occ_byte(input logic [AW:0] cnt);
        logic [31:0] wide;
        wide = 32'(cnt);
        return (wide > 32'd255) ? 8'hFF : wide[7:0];
    endfunction

    tx_state_e     state_q, state_d;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          rx_enable_q, rx_enable_d;
    logic          rx_ovr_q, rx_ovr_d, tx_drop_q, tx_drop_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          uart_tx_en_q, uart_tx_en_d;
    logic [31:0]   uart_data_send_q, uart_data_send_d;
    logic          irq_en_s;

    logic          rd_data_s, wr_data_s, wr_stat_s, wr_ctrl_s;
    logic          tx_full_s, tx_empty_s, tx_idle_s, tx_push_s, tx_pop_s;
    logic          rx_avail_s, rx_full_s, rx_in_s, rx_push_s, rx_pop_s, rx_ovr_set_s;
    logic [31:0]   status_s, ctrl_s;
    logic          unused_s;

    assign unused_s = ^{addr[1:0], wdata[31:8], uart_data_recv[31:8]};

    // Bus decode and FIFO flag derivation.
    always_comb begin
        rd_data_s    = mem_read  && (addr[3:2] == A_DATA);
        wr_data_s    = mem_write && (addr[3:2] == A_DATA);
        wr_stat_s    = mem_write && (addr[3:2] == A_STAT);
        wr_ctrl_s    = mem_write && (addr[3:2] == A_CTRL);
        tx_full_s    = (tx_count_q == DEPTH_C);
        tx_empty_s   = (tx_count_q == CNT_ZERO);
        tx_idle_s    = tx_empty_s && (state_q == ST_IDLE);
        rx_avail_s   = (rx_count_q != CNT_ZERO);
        rx_full_s    = (rx_count_q == DEPTH_C);
        tx_push_s    = wr_data_s && !tx_full_s;
        rx_pop_s     = rd_data_s && rx_avail_s;
        rx_in_s      = uart_rx_res && rx_enable_q;
        // A pop in the same cycle frees the slot the incoming byte needs.
        rx_push_s    = rx_in_s && (!rx_full_s || rx_pop_s);
        rx_ovr_set_s = rx_in_s && rx_full_s && !rx_pop_s;
    end

    // TX pacing FSM: one byte handed to the controller per completed transmit.
    always_comb begin
        state_d          = state_q;
        tx_pop_s         = 1'b0;
        uart_data_send_d = uart_data_send_q;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_pop_s = 1'b1;
                state_d  = ST_BUSY;
            end
            ST_BUSY: begin
                if (uart_tx_res) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        uart_tx_en_d = (state_d == ST_LOAD);
        if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
            uart_data_send_d = {24'd0, tx_mem_q[tx_rptr_q]};
        end else begin
            uart_data_send_d = uart_data_send_q;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        tx_wptr_d = tx_push_s ? (tx_wptr_q + PTR_ONE) : tx_wptr_q;
        tx_rptr_d = tx_pop_s  ? (tx_rptr_q + PTR_ONE) : tx_rptr_q;
        rx_wptr_d = rx_push_s ? (rx_wptr_q + PTR_ONE) : rx_wptr_q;
        rx_rptr_d = rx_pop_s  ? (rx_rptr_q + PTR_ONE) : rx_rptr_q;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
    end

    // Sticky error bits (a CPU clear beats a same-cycle set) and CTRL rx_enable.
    always_comb begin
        if (wr_stat_s && wdata[3]) begin
            rx_ovr_d = 1'b0;
        end else if (rx_ovr_set_s) begin
            rx_ovr_d = 1'b1;
        end else begin
            rx_ovr_d = rx_ovr_q;
        end
        if (wr_stat_s && wdata[4]) begin
            tx_drop_d = 1'b0;
        end else if (wr_data_s && tx_full_s) begin
            tx_drop_d = 1'b1;
        end else begin
            tx_drop_d = tx_drop_q;
        end
        if (wr_ctrl_s) begin
            rx_enable_d = wdata[0];
        end else begin
            rx_enable_d = rx_enable_q;
        end
    end

    // Read-data mux; all fields come from pre-write register state.
    always_comb begin
        status_s = {16'd0, occ_byte(rx_count_q), 3'd0, tx_drop_q, rx_ovr_q,
                    tx_idle_s, tx_full_s, rx_avail_s};
        ctrl_s   = {30'd0, irq_en_s, rx_enable_q};
        rdata_d  = rdata_q;
        if (mem_read) begin
            case (addr[3:2])
                A_DATA:  rdata_d = rx_avail_s ? {24'd0, rx_mem_q[rx_rptr_q]} : 32'd0;
                A_STAT:  rdata_d = status_s;
                A_CTRL:  rdata_d = ctrl_s;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wptr_q] <= wdata[7:0];
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wptr_q] <= uart_data_recv[7:0];
        end
    end

    // Control and status state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            tx_wptr_q        <= '0;
            tx_rptr_q        <= '0;
            rx_wptr_q        <= '0;
            rx_rptr_q        <= '0;
            tx_count_q       <= CNT_ZERO;
            rx_count_q       <= CNT_ZERO;
            rx_enable_q      <= 1'b0;
            rx_ovr_q         <= 1'b0;
            tx_drop_q        <= 1'b0;
            rdata_q          <= 32'd0;
            uart_tx_en_q     <= 1'b0;
            uart_data_send_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            tx_wptr_q        <= tx_wptr_d;
            tx_rptr_q        <= tx_rptr_d;
            rx_wptr_q        <= rx_wptr_d;
            rx_rptr_q        <= rx_rptr_d;
            tx_count_q       <= tx_count_d;
            rx_count_q       <= rx_count_d;
            rx_enable_q      <= rx_enable_d;
            rx_ovr_q         <= rx_ovr_d;
            tx_drop_q        <= tx_drop_d;
            rdata_q          <= rdata_d;
            uart_tx_en_q     <= uart_tx_en_d;
            uart_data_send_q <= uart_data_send_d;
        end
    end

`ifdef UART_BRIDGE_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // Interrupt enable bit and level interrupt while RX data is pending.
    always_comb begin
        if (wr_ctrl_s) begin
            irq_en_d = wdata[1];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = irq_en_q && rx_avail_s;
    end

    // Interrupt registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_s = irq_en_q;
    assign irq      = irq_q;
`else
    assign irq_en_s = 1'b0;
    assign irq      = 1'b0;
`endif

    assign rdata          = rdata_q;
    assign uart_tx_en     = uart_tx_en_q;
    assign uart_data_send = uart_data_send_q;
    assign uart_rx_en     = rx_enable_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: register table plus TX/RX/reset/IRQ sequences.
`timescale 1ns/1ps
module tb_uart_mmio_bridge;

    localparam int DEPTH = 16;
`ifdef UART_BRIDGE_IRQ_EN
    localparam logic [31:0] CTRL_ALL = 32'h3;
    localparam logic [31:0] IRQ_ON   = 32'h1;
`else
    localparam logic [31:0] CTRL_ALL = 32'h1;
    localparam logic [31:0] IRQ_ON   = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata, uart_data_send, uart_data_recv;
    logic        irq, uart_tx_en, uart_tx_res, uart_rx_en, uart_rx_res;

    uart_mmio_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq),
        .uart_tx_en(uart_tx_en), .uart_data_send(uart_data_send), .uart_tx_res(uart_tx_res),
        .uart_rx_en(uart_rx_en), .uart_data_recv(uart_data_recv), .uart_rx_res(uart_rx_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [12];
    int          checks_total  = 0;
    int          checks_passed = 0;
    int          tx_pulses     = 0;
    int          saved_pulses;
    logic [31:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic [7:0]  tx_exp_q [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Bus access starting and ending on a falling edge; read results checked via scoreboard.
    task automatic bus(input logic rd, input logic wr, input logic [3:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input string name);
        if (rd) begin
            rd_exp_q.push_back(exp);
            rd_name_q.push_back(name);
        end
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        if (rd) check32(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d, 32'h0, "");
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        bus(1'b1, 1'b0, a, 32'h0, exp, name);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        uart_data_recv = {24'd0, b}; uart_rx_res = 1'b1;
        @(negedge clk);
        uart_rx_res = 1'b0;
    endtask

    task automatic tx_done_pulse();
        uart_tx_res = 1'b1;
        @(negedge clk);
        uart_tx_res = 1'b0;
    endtask

    // Transmit monitor: every load pulse must match the next byte the bench queued.
    always @(negedge clk) begin
        if (reset && uart_tx_en) begin
            tx_pulses++;
            if (tx_exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL tx_unexpected: uart_tx_en=1 data 0x%08h, expected no pulse", uart_data_send);
            end else begin
                check32("tx_data", uart_data_send, {24'd0, tx_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'h4, 32'h0,         32'h4,    "status_reset"};
        vecs[1]  = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h0,    "ctrl_reset"};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 32'h0,         32'h0,    "data_empty"};
        vecs[3]  = '{1'b1, 1'b0, 4'hC, 32'h0,         32'h0,    "reserved_rd"};
        vecs[4]  = '{1'b0, 1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0,    "ctrl_wr_all"};
        vecs[5]  = '{1'b1, 1'b0, 4'h8, 32'h0,         CTRL_ALL, "ctrl_rd_all"};
        vecs[6]  = '{1'b0, 1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0,    "reserved_wr"};
        vecs[7]  = '{1'b1, 1'b0, 4'hC, 32'h0,         32'h0,    "reserved_rd2"};
        vecs[8]  = '{1'b1, 1'b0, 4'h8, 32'h0,         CTRL_ALL, "ctrl_after_rsvd"};
        vecs[9]  = '{1'b1, 1'b1, 4'h8, 32'h0,         CTRL_ALL, "ctrl_rw_prewrite"};
        vecs[10] = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h0,    "ctrl_rw_post"};
        vecs[11] = '{1'b1, 1'b0, 4'h6, 32'h0,         32'h4,    "status_low_addr"};

        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = 4'h0; wdata = 32'h0;
        uart_tx_res = 1'b0; uart_rx_res = 1'b0; uart_data_recv = 32'h0;
        repeat (3) @(negedge clk);
        check32("rst_rdata", rdata, 32'h0);
        check32("rst_irq", 32'(irq), 32'h0);
        check32("rst_tx_en", 32'(uart_tx_en), 32'h0);
        check32("rst_data_send", uart_data_send, 32'h0);
        check32("rst_rx_en", 32'(uart_rx_en), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].exp, vecs[i].name);
        end

        // Single TX with exact pulse timing.
        tx_exp_q.push_back(8'hA5);
        wr(4'h0, 32'h0000_00A5);
        check32("tx_en_not_yet", 32'(uart_tx_en), 32'h0);
        @(negedge clk);
        check32("tx_en_pulse", 32'(uart_tx_en), 32'h1);
        check32("tx_send_val", uart_data_send, 32'hA5);
        @(negedge clk);
        check32("tx_en_one_cycle", 32'(uart_tx_en), 32'h0);
        rd(4'h4, 32'h0, "status_tx_busy");
        tx_done_pulse();
        rd(4'h4, 32'h4, "status_tx_idle");
        check32("tx_send_held", uart_data_send, 32'hA5);

        // TX overflow with the controller stalled, then drain.
        for (int i = 0; i < 18; i++) begin
            if (i < 17) tx_exp_q.push_back(8'h10 + 8'(i));
            wr(4'h0, 32'h10 + 32'(i));
        end
        rd(4'h4, 32'h12, "status_tx_ovf");
        wr(4'h4, 32'h10);
        rd(4'h4, 32'h02, "status_drop_clr");
        for (int i = 0; i < 17; i++) begin
            tx_done_pulse();
            @(negedge clk);
            check32("tx_b2b_pulse", 32'(uart_tx_en), (i < 16) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        rd(4'h4, 32'h4, "status_tx_drained");

        // RX path: ignored while disabled, then captured.
        rx_pulse(8'h55);
        rd(4'h4, 32'h4, "status_rx_disabled");
        wr(4'h8, 32'h1);
        check32("rx_en_level", 32'(uart_rx_en), 32'h1);
        rx_pulse(8'h3C);
        rd(4'h4, 32'h105, "status_rx_one");
        rd(4'h0, 32'h3C, "data_rx_one");
        rd(4'h4, 32'h4, "status_rx_empty");

        // RX overrun, clear, simultaneous pop/push, clear-beats-set, drain order.
        for (int i = 0; i < 16; i++) rx_pulse(8'h80 + 8'(i));
        rd(4'h4, 32'h1005, "status_rx_full");
        rx_pulse(8'hEE);
        rd(4'h4, 32'h100D, "status_rx_ovr");
        wr(4'h4, 32'h08);
        rd(4'h4, 32'h1005, "status_ovr_clr");
        rd_exp_q.push_back(32'h80);
        rd_name_q.push_back("data_pop_push");
        mem_read = 1'b1; addr = 4'h0; uart_data_recv = 32'h99; uart_rx_res = 1'b1;
        @(negedge clk);
        mem_read = 1'b0; uart_rx_res = 1'b0;
        check32(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
        rd(4'h4, 32'h1005, "status_pop_push");
        mem_write = 1'b1; addr = 4'h4; wdata = 32'h08; uart_data_recv = 32'h77; uart_rx_res = 1'b1;
        @(negedge clk);
        mem_write = 1'b0; uart_rx_res = 1'b0;
        rd(4'h4, 32'h1005, "status_clr_wins");
        for (int i = 1; i < 16; i++) rd(4'h0, 32'h80 + 32'(i), "data_drain");
        rd(4'h0, 32'h99, "data_drain_last");
        rd(4'h4, 32'h4, "status_rx_drained");

        // Interrupt behaviour.
        wr(4'h8, 32'h3);
        rd(4'h8, CTRL_ALL, "ctrl_irq");
        rx_pulse(8'h42);
        @(negedge clk);
        check32("irq_set", 32'(irq), IRQ_ON);
        rd(4'h0, 32'h42, "data_irq");
        check32("irq_still", 32'(irq), IRQ_ON);
        @(negedge clk);
        check32("irq_clear", 32'(irq), 32'h0);

        // Reset while BUSY with five bytes queued.
        wr(4'h8, 32'h1);
        tx_exp_q.push_back(8'h61);
        for (int i = 0; i < 6; i++) wr(4'h0, 32'h61 + 32'(i));
        rd(4'h8, 32'h1, "ctrl_before_rst");
        reset = 1'b0;
        #1;
        check32("arst_rdata", rdata, 32'h0);
        check32("arst_tx_en", 32'(uart_tx_en), 32'h0);
        check32("arst_data_send", uart_data_send, 32'h0);
        check32("arst_rx_en", 32'(uart_rx_en), 32'h0);
        check32("arst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        saved_pulses = tx_pulses;
        tx_done_pulse();
        repeat (4) @(negedge clk);
        #1;
        check32("no_tx_after_rst", 32'(tx_pulses), 32'(saved_pulses));
        @(negedge clk);
        rd(4'h4, 32'h4, "status_after_rst");
        rd(4'h8, 32'h0, "ctrl_after_rst");
        check32("tx_queue_drained", 32'(tx_exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
